// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals for the write-port arbiter.
// The arbiter takes the master modport; the source/FIFO side takes the slave modport.
interface fifo_wr_arbiter_if #(
   parameter int DATA = 8,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req;
   logic [NREQ*DATA-1:0] src_data;
   logic [NREQ-1:0]      src_last;
   logic [NREQ-1:0]      ack;
   logic [NREQ-1:0]      gnt;
   logic                 fifo_full;
   logic                 fifo_we;
   logic [DATA-1:0]      fifo_din;
   logic                 busy;
   logic [7:0]           words_cnt;

   modport master (
      input  req, src_data, src_last, fifo_full,
      output ack, gnt, fifo_we, fifo_din, busy, words_cnt
   );

   modport slave (
      output req, src_data, src_last, fifo_full,
      input  ack, gnt, fifo_we, fifo_din, busy, words_cnt
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ bursting sources.
// Grants are registered; the write path is combinational so a full flag blocks that same cycle.
module fifo_wr_arbiter #(
   parameter int DATA     = 8,
   parameter int NREQ     = 4,
   parameter int MAXBURST = 8
) (
   input logic               wclk,
   input logic               reset,
   fifo_wr_arbiter_if.master bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   gIdx_q, gIdx_d;
   logic [PW-1:0]   rrPtr_q, rrPtr_d;
   logic [7:0]      wordsCnt_q, wordsCnt_d;

   logic            found;
   logic [PW-1:0]   selIdx;
   logic [PW-1:0]   nextPtr;
   logic            accept;
   logic            endBurst;

   // Search upward from the round-robin pointer, wrapping, for the first active request.
   always_comb begin
      found  = 1'b0;
      selIdx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && bus.req[(int'(rrPtr_q) + k) % NREQ]) begin
            found  = 1'b1;
            selIdx = PW'((int'(rrPtr_q) + k) % NREQ);
         end
      end
   end

   assign nextPtr  = (int'(gIdx_q) == NREQ - 1) ? '0 : gIdx_q + 1'b1;
   assign accept   = (state_q == BURST) && !reset && bus.req[gIdx_q] && !bus.fifo_full;
   assign endBurst = bus.src_last[gIdx_q] || (wordsCnt_q == 8'(MAXBURST - 1));

   assign bus.fifo_we   = accept;
   assign bus.fifo_din  = bus.src_data[int'(gIdx_q)*DATA +: DATA];
   assign bus.ack       = accept ? gnt_q : '0;
   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state_q == BURST);
   assign bus.words_cnt = wordsCnt_q;

   // A burst closes on its last word, on the length cap, or when the source withdraws.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gIdx_d     = gIdx_q;
      rrPtr_d    = rrPtr_q;
      wordsCnt_d = wordsCnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = BURST;
               gnt_d      = NREQ'(1) << selIdx;
               gIdx_d     = selIdx;
               wordsCnt_d = '0;
            end
         end
         default: begin
            if (!bus.req[gIdx_q]) begin
               state_d    = IDLE;
               gnt_d      = '0;
               rrPtr_d    = nextPtr;
               wordsCnt_d = '0;
            end else if (accept) begin
               if (endBurst) begin
                  state_d    = IDLE;
                  gnt_d      = '0;
                  rrPtr_d    = nextPtr;
                  wordsCnt_d = '0;
               end else begin
                  wordsCnt_d = wordsCnt_q + 8'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge wclk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gIdx_q     <= '0;
         rrPtr_q    <= '0;
         wordsCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gIdx_q     <= gIdx_d;
         rrPtr_q    <= rrPtr_d;
         wordsCnt_q <= wordsCnt_d;
      end
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter for the async FIFO write side, in the wclk domain.
- Shares one FIFO write port (we/datain, back-pressured by full) among NREQ requesters.
- Each grant covers a burst: it ends on the source's last flag, when MAXBURST words are reached, or when the source withdraws its request.
- Guarantees no write while full and a bounded wait for every requester.

Parameters:
- DATA, 8, word width; equals FIFO data width.
- NREQ, 4, number of requesters (2..8).
- MAXBURST, 8, maximum words per grant (1..255).

Ports:
- wclk  input  1  write-domain clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- req  input  NREQ  per-source request; held high while the source has a word pending.
- src_data  input  NREQ*DATA  flattened source words; source i occupies bits [i*DATA +: DATA].
- src_last  input  NREQ  marks the source's current word as the final word of its burst.
- ack  output  NREQ  combinational; word of source i accepted this cycle; source advances on the same edge.
- gnt  output  NREQ  registered one-hot grant; all zero when idle.
- fifo_full  input  1  full flag from the FIFO (wclk domain).
- fifo_we  output  1  combinational FIFO write enable.
- fifo_din  output  DATA  combinational word for the FIFO, equal to src_data of the granted source.
- busy  output  1  registered; high in state BURST.
- words_cnt  output  8  registered; words accepted in the current burst.

Behaviour:
- Reset values, applied on the first edge with reset high:
  - state=IDLE, gnt=0, busy=0, words_cnt=0, rr_ptr=0.
  - ack=0 and fifo_we=0 whenever reset is high, so no write occurs during a reset cycle.
- States: IDLE, BURST.
- IDLE:
  - If req!=0, select the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Next edge: gnt<=onehot(sel), state<=BURST, words_cnt<=0.
  - No write occurs in IDLE, so there is exactly one arbitration bubble between bursts.
- BURST, with g = granted index:
  - Accept condition: accept = req[g] & ~fifo_full.
  - fifo_we = accept; fifo_din = src_data[g]; ack = gnt when accept, else 0.
  - On accept: words_cnt increments.
  - End of burst: on accept with (src_last[g] | words_cnt==MAXBURST-1), next edge state<=IDLE, gnt<=0, rr_ptr<=(g+1) mod NREQ.
  - fifo_full=1 with req[g]=1: stall; hold grant and words_cnt; no ack, no write. The stall has no timeout.
  - req[g]=0 (abort): next edge state<=IDLE, gnt<=0, rr_ptr<=(g+1) mod NREQ; no write that cycle.
- Requests from non-granted sources are ignored until the next IDLE cycle. They must stay asserted to be considered.
- Fairness: a requester holding req waits at most (NREQ-1) bursts of at most MAXBURST words each, plus stall time.
- The write path is combinational from fifo_full, so a full flag seen on a cycle blocks that cycle's write. The arbiter can never overflow the FIFO.
- words_cnt wraps only by MAXBURST termination; it never exceeds MAXBURST-1 before clearing.
- Reset mid-burst: the burst is dropped at once; the source re-arbitrates after reset and must resend un-acked words.

Test Plan:
- Single burst: reset 2 cycles; req=0001 with words 0x0A, 0x0B, 0x0C, last on 0x0C -> gnt=0001 one cycle after req; three consecutive fifo_we pulses carrying 0x0A, 0x0B, 0x0C; then gnt=0, rr_ptr=1.
- Round-robin: req=1011 held, each source sending 1-word bursts with last=1 -> grant order 0,1,3,0,1,3; one IDLE cycle between grants; source 2 never granted.
- Full stall: source 1 mid-burst after 2 words; fifo_full=1 for 5 cycles -> fifo_we=0, ack=0, gnt=0010 held, words_cnt=2 held; after full drops, writes resume with the same pending word.
- MAXBURST cut: MAXBURST=8; source 2 streams 12 words, last never set -> exactly 8 writes; gnt clears; with req=0110 the next grant goes to source 1 after wrapping; source 2's remaining 4 words go in a later grant.
- Abort: source 0 drops req after 3 accepted words -> no write on the drop cycle; IDLE next edge; rr_ptr=1.
- Reset mid-burst: reset high for 1 cycle during the 4th word of a burst -> no fifo_we on the reset cycle; gnt=0, busy=0, words_cnt=0, rr_ptr=0 after the edge.
